edge_detect_multi: RTL and testbench
====================================

EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of independent input channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per channel (0 = bypass, 0..4).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 3: consecutive stable cycles required to accept a level change (1..255).
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port sig  input  WIDTH: raw, possibly asynchronous, channel inputs.
REQ-007 SHALL have port mode  input  2: detect select; 00 rise, 01 fall, 10 both, 11 disabled; applies to all channels.
REQ-008 SHALL have port clr  input  WIDTH: per-channel pending-flag clear, sampled each clock.
REQ-009 SHALL have port level  output  WIDTH: registered debounced level per channel.
REQ-010 SHALL have port pulse  output  WIDTH: registered one-cycle edge strobe per channel.
REQ-011 SHALL have port pending  output  WIDTH: sticky edge-seen flag per channel.
REQ-012 SHALL have port any_pending  output  1: OR-reduction of pending.

Function
REQ-013 SHALL pass each sig bit through SYNC_STAGES cascaded flops; synchronised value s[i] = final stage, or sig[i] directly when SYNC_STAGES = 0.
REQ-014 SHALL keep per channel a counter cnt[i] of width clog2(DEBOUNCE_CYCLES+1), minimum 1 bit.
REQ-015 SHALL, each clock with s[i] == level[i], set cnt[i] to 0.
REQ-016 SHALL, each clock with s[i] != level[i] and cnt[i] < DEBOUNCE_CYCLES-1, increment cnt[i].
REQ-017 SHALL, each clock with s[i] != level[i] and cnt[i] == DEBOUNCE_CYCLES-1, load level[i] <= s[i] and cnt[i] <= 0 (an update event).
REQ-018 SHALL reject any synchronised glitch shorter than DEBOUNCE_CYCLES cycles: level and pulse unchanged, counter back to 0.
REQ-019 SHALL assert pulse[i] for exactly one cycle, on the same edge level[i] changes, iff the update event matches mode: 0->1 for 00, 1->0 for 01, either for 10, never for 11; pulse[i] = 0 in all other cycles.
REQ-020 SHALL give latency from a clean sig change (held stable) to level/pulse of SYNC_STAGES + DEBOUNCE_CYCLES clock edges.
REQ-021 SHALL use the mode value sampled on the same edge as the update event; mode changes need no idle period and have no effect on level tracking.
REQ-022 SHALL set pending[i] <= 1 on any edge where pulse[i] is set; otherwise clear it when clr[i] = 1; otherwise hold.
REQ-023 SHALL give set priority over clear: simultaneous update event and clr[i] leaves pending[i] = 1.
REQ-024 SHALL register any_pending as the OR of the next-state pending vector, so it tracks pending with zero relative skew.
REQ-025 SHALL process all channels independently; simultaneous events on several channels each produce their own pulse and pending.

Reset
REQ-026 SHALL, on a clock edge with rst = 1, clear all sync flops, cnt, level, pulse, pending, any_pending to 0; rst overrides all other inputs.
REQ-027 SHALL discard any in-progress debounce count on reset; counting restarts from 0 on the first edge with rst = 0.
REQ-028 SHALL treat level reset value 0 as real: a sig held high through reset yields a rise event (pulse if mode 00/10) SYNC_STAGES + DEBOUNCE_CYCLES edges after rst deasserts.

Verification (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=3)
REQ-029 SHALL cover: mode=00, sig[0] 0->1 held -> pulse[0]=1 for one cycle at the 5th edge after the change, level[0]=1 from that edge, pending[0]=1, any_pending=1.
REQ-030 SHALL cover: mode=00, sig[1] high for 2 cycles then low -> level[1], pulse[1], pending[1] stay 0.
REQ-031 SHALL cover: mode=10, sig[2] 0->1, hold 10 cycles, 1->0 -> two single-cycle pulses 10 cycles apart; mode=11 same stimulus -> level toggles, no pulse.
REQ-032 SHALL cover: clr[0]=1 on the same edge as a pulse[0] event -> pending[0] stays 1; clr[0]=1 one cycle later -> pending[0]=0, any_pending=0.
REQ-033 SHALL cover: rst=1 for one cycle after 2 of 3 debounce counts with sig[3] held high -> all outputs 0 next cycle; pulse[3] appears 5 edges after rst deasserts.
REQ-034 SHALL cover: sig=4'b1111 applied at once, mode=00 -> pulse=4'b1111 on a single cycle.

Source files
------------

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronise + debounce + edge detector with sticky per-channel flags.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clock edges from a clean input change to level/pulse.
// Backpressure: none; pending holds each detected edge until cleared through clr.
module edge_detect_multi #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] pulse,
  output logic [WIDTH-1:0] pending,
  output logic             any_pending
);

  // Counter wide enough to hold DEBOUNCE_CYCLES, never narrower than one bit.
  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  // Count value at which the next mismatching cycle commits the new level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_pulse;
  logic [WIDTH-1:0] r_pending;
  logic             r_any_pending;
  logic [CNT_W-1:0] r_cnt     [WIDTH];
  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_update;
  logic [WIDTH-1:0] w_level_nxt;
  logic [WIDTH-1:0] w_pulse_nxt;
  logic [WIDTH-1:0] w_pending_nxt;
  logic             w_rise_en;
  logic             w_fall_en;

  // Synchroniser chain; with zero stages the raw input feeds the debouncer directly.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = sig;
    end else begin : g_sync
      logic [WIDTH-1:0] r_sync [SYNC_STAGES];

      // Shift each channel through the synchroniser flops; reset clears the whole chain.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            r_sync[k] <= '0;
          end
        end else begin
          r_sync[0] <= sig;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
          end
        end
      end

      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Mode is evaluated on the same edge as the update event, so it may change at any time.
  assign w_rise_en = (mode == MODE_RISE) || (mode == MODE_BOTH);
  assign w_fall_en = (mode == MODE_FALL) || (mode == MODE_BOTH);

  // Per-channel debounce: count consecutive mismatching cycles, commit on the last one.
  always_comb begin
    w_update    = '0;
    w_level_nxt = r_level;
    w_pulse_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = '0;
      if (w_s[i] != r_level[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          // Stable long enough: accept the new level, counter restarts from zero.
          w_update[i]    = 1'b1;
          w_level_nxt[i] = w_s[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end
      end
      // A mismatch that ends early leaves w_cnt_nxt at zero, discarding the glitch.
      w_pulse_nxt[i] = w_update[i] & (w_s[i] ? w_rise_en : w_fall_en);
    end
  end

  // Sticky flag: a new pulse wins over a simultaneous clear.
  assign w_pending_nxt = w_pulse_nxt | (r_pending & ~clr);

  // State registers; any_pending is built from the next-state vector to stay aligned with pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level       <= '0;
      r_pulse       <= '0;
      r_pending     <= '0;
      r_any_pending <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_level       <= w_level_nxt;
      r_pulse       <= w_pulse_nxt;
      r_pending     <= w_pending_nxt;
      r_any_pending <= |w_pending_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign level       = r_level;
  assign pulse       = r_pulse;
  assign pending     = r_pending;
  assign any_pending = r_any_pending;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=3).
// Expected pulse events are queued by the stimulus; a negedge monitor pops and compares them.
// Static state (reset, glitch rejection, clears) is compared directly by the stimulus process.
module tb_edge_detect_multi;

  logic       clk;
  logic       rst;
  logic [3:0] sig;
  logic [1:0] mode;
  logic [3:0] clr;
  logic [3:0] level;
  logic [3:0] pulse;
  logic [3:0] pending;
  logic       any_pending;

  typedef struct {
    int         cyc;
    logic [3:0] pulse;
    logic [3:0] level;
    logic [3:0] pending;
    logic       any;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc;
  int   n_total;
  int   n_pass;

  edge_detect_multi #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sig(sig),
    .mode(mode),
    .clr(clr),
    .level(level),
    .pulse(pulse),
    .pending(pending),
    .any_pending(any_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter used to timestamp expected events.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_evt(input int at, input logic [3:0] p, input logic [3:0] l, input logic [3:0] pd);
    exp_t x;
    x.cyc     = at;
    x.pulse   = p;
    x.level   = l;
    x.pending = pd;
    x.any     = |pd;
    q.push_back(x);
  endtask

  // Monitor: every nonzero pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc < cyc) begin
      chk("missed_pulse_cycle", cyc, q[0].cyc);
      q.delete(0);
    end
    if (pulse !== 4'b0000) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {28'd0, pulse}, 32'd0);
      end else begin
        e = q[0];
        q.delete(0);
        chk("evt_cycle",   cyc, e.cyc);
        chk("evt_pulse",   {28'd0, pulse}, {28'd0, e.pulse});
        chk("evt_level",   {28'd0, level}, {28'd0, e.level});
        chk("evt_pending", {28'd0, pending}, {28'd0, e.pending});
        chk("evt_any",     {31'd0, any_pending}, {31'd0, e.any});
      end
    end
  end

  initial begin
    int n;
    cyc     = 0;
    n_total = 0;
    n_pass  = 0;
    rst     = 1'b1;
    sig     = 4'b0000;
    mode    = 2'b00;
    clr     = 4'b0000;

    // Reset state
    tick(3);
    chk("rst_level",   {28'd0, level}, 32'd0);
    chk("rst_pulse",   {28'd0, pulse}, 32'd0);
    chk("rst_pending", {28'd0, pending}, 32'd0);
    chk("rst_any",     {31'd0, any_pending}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Rise on channel 0, mode rise: pulse 5 edges after the change
    mode = 2'b00;
    sig  = 4'b0001;
    n    = cyc;
    expect_evt(n + 5, 4'b0001, 4'b0001, 4'b0001);
    tick(7);
    chk("rise0_level",   {28'd0, level}, 32'h1);
    chk("rise0_pulse",   {28'd0, pulse}, 32'h0);
    chk("rise0_pending", {28'd0, pending}, 32'h1);
    chk("rise0_any",     {31'd0, any_pending}, 32'h1);
    clr = 4'b0001;
    tick(1);
    clr = 4'b0000;
    chk("clr0_pending", {28'd0, pending}, 32'h0);
    chk("clr0_any",     {31'd0, any_pending}, 32'h0);

    // Fall on channel 0 with clear coinciding with the pulse, then clear one cycle later
    mode = 2'b01;
    sig  = 4'b0000;
    n    = cyc;
    expect_evt(n + 5, 4'b0001, 4'b0000, 4'b0001);
    tick(4);
    clr = 4'b0001;
    tick(1);
    tick(1);
    clr = 4'b0000;
    chk("clr_late_pending", {28'd0, pending}, 32'h0);
    chk("clr_late_any",     {31'd0, any_pending}, 32'h0);
    chk("fall0_level",      {28'd0, level}, 32'h0);

    // Two-cycle glitch on channel 1 is rejected
    mode = 2'b00;
    sig  = 4'b0010;
    tick(2);
    sig  = 4'b0000;
    tick(8);
    chk("glitch_level",   {28'd0, level}, 32'h0);
    chk("glitch_pending", {28'd0, pending}, 32'h0);

    // Both-edge mode on channel 2: two pulses ten cycles apart
    mode = 2'b10;
    sig  = 4'b0100;
    n    = cyc;
    expect_evt(n + 5, 4'b0100, 4'b0100, 4'b0100);
    tick(10);
    sig  = 4'b0000;
    expect_evt(n + 15, 4'b0100, 4'b0000, 4'b0100);
    tick(8);
    chk("both_pending", {28'd0, pending}, 32'h4);
    clr = 4'b1111;
    tick(1);
    clr = 4'b0000;

    // Disabled mode: level still tracks, no pulse or pending
    mode = 2'b11;
    sig  = 4'b0100;
    tick(10);
    chk("dis_level_hi", {28'd0, level}, 32'h4);
    chk("dis_pending",  {28'd0, pending}, 32'h0);
    sig  = 4'b0000;
    tick(8);
    chk("dis_level_lo", {28'd0, level}, 32'h0);
    chk("dis_any",      {31'd0, any_pending}, 32'h0);

    // All channels rise together
    mode = 2'b00;
    sig  = 4'b1111;
    n    = cyc;
    expect_evt(n + 5, 4'b1111, 4'b1111, 4'b1111);
    tick(7);
    clr = 4'b1111;
    tick(1);
    clr = 4'b0000;
    chk("all_clr_pending", {28'd0, pending}, 32'h0);
    sig = 4'b0000;
    tick(8);
    chk("all_fall_level", {28'd0, level}, 32'h0);

    // Reset mid-debounce on channel 3, then the held-high input rises afresh
    sig = 4'b1000;
    n   = cyc;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("midrst_level",   {28'd0, level}, 32'h0);
    chk("midrst_pulse",   {28'd0, pulse}, 32'h0);
    chk("midrst_pending", {28'd0, pending}, 32'h0);
    chk("midrst_any",     {31'd0, any_pending}, 32'h0);
    rst = 1'b0;
    expect_evt(n + 10, 4'b1000, 4'b1000, 4'b1000);
    tick(10);
    chk("post_rst_level", {28'd0, level}, 32'h8);

    chk("queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
